// File: rtl/decode_stage_pipe_pkg.sv
// Shared definitions for the decode stage: instruction field geometry and
// the opcode set that the downstream opcode decoder will interpret.
package decode_stage_pipe_pkg;

    // Opcode width is whatever the instruction leaves after three register fields.
    function automatic int op_width(input int inst_w, input int reg_aw);
        return inst_w - 3 * reg_aw;
    endfunction

    function automatic int rs1_msb(input int reg_aw);
        return 3 * reg_aw - 1;
    endfunction

    function automatic int rs2_msb(input int reg_aw);
        return 2 * reg_aw - 1;
    endfunction

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_SLL = 4'h6,
        OP_SRL = 4'h7,
        OP_LD  = 4'h8,
        OP_ST  = 4'h9,
        OP_BEQ = 4'hA,
        OP_JMP = 4'hB
    } opcode_e;

endpackage

// File: rtl/decode_stage_pipe_regfile_2r1w.sv
// Two-read, one-write register file. Reads are combinational and see a write
// landing in the same cycle; R0 can be hardwired to zero.
module regfile_2r1w
    import decode_stage_pipe_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic              wr_ok;

    assign wr_ok = i_we && !(ZERO_REG && (i_waddr == '0));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_ok) begin
            rf_q[i_waddr] <= i_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] addr);
        if (ZERO_REG && (addr == '0)) begin
            return '0;
        end else if (i_we && (i_waddr == addr)) begin
            return i_wdata;
        end
        return rf_q[addr];
    endfunction

    always_comb begin
        o_rdata1 = read_port(i_raddr1);
        o_rdata2 = read_port(i_raddr2);
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: splits the instruction, reads operands, and holds the result
// in an ID/EX register with valid/ready on both sides, flush and operand refresh.
module decode_stage_pipe
    import decode_stage_pipe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int INST_W     = 16,
    parameter int REG_AW     = 4,
    parameter bit ZERO_REG   = 1'b1,
    localparam int OP_W      = op_width(INST_W, REG_AW)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [INST_W-1:0] i_inst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_wb_en,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OP_W-1:0]   o_op,
    output logic [REG_AW-1:0] o_rs1,
    output logic [REG_AW-1:0] o_rs2,
    output logic [REG_AW-1:0] o_rd,
    output logic [DATA_W-1:0] o_src1,
    output logic [DATA_W-1:0] o_src2
);

    localparam int RS1_MSB = rs1_msb(REG_AW);
    localparam int RS2_MSB = rs2_msb(REG_AW);

    logic [OP_W-1:0]   op_f;
    logic [REG_AW-1:0] rs1_f, rs2_f, rd_f;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic              ld, wb_eff;

    logic              valid_q, valid_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;

    assign op_f  = i_inst[INST_W-1 -: OP_W];
    assign rs1_f = i_inst[RS1_MSB -: REG_AW];
    assign rs2_f = i_inst[RS2_MSB -: REG_AW];
    assign rd_f  = i_inst[REG_AW-1:0];

    regfile_2r1w #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG)
    ) u_rf (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_we     (i_wb_en),
        .i_waddr  (i_wb_addr),
        .i_wdata  (i_wb_data),
        .i_raddr1 (rs1_f),
        .i_raddr2 (rs2_f),
        .o_rdata1 (rdata1),
        .o_rdata2 (rdata2)
    );

    // Handshake: o_valid/i_ready transfer the ID/EX contents when both are
    // high at a rising edge; i_valid/o_ready do the same for the incoming
    // instruction, and o_ready never looks at i_valid.
    assign o_ready = !valid_q || i_ready;
    assign ld      = i_valid && o_ready && !i_flush;
    // A write that actually lands (R0 writes are dropped when hardwired).
    assign wb_eff  = i_wb_en && !(ZERO_REG && (i_wb_addr == '0));

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (ld) begin
            valid_d = 1'b1;
            op_d    = op_f;
            rs1_d   = rs1_f;
            rs2_d   = rs2_f;
            rd_d    = rd_f;
            src1_d  = rdata1;
            src2_d  = rdata2;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: keep held operands coherent with write-back traffic.
            if (wb_eff && (i_wb_addr == rs1_q)) src1_d = i_wb_data;
            if (wb_eff && (i_wb_addr == rs2_q)) src2_d = i_wb_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
        end
    end

    assign o_valid = valid_q;
    assign o_op    = op_q;
    assign o_rs1   = rs1_q;
    assign o_rs2   = rs2_q;
    assign o_rd    = rd_q;
    assign o_src1  = src1_q;
    assign o_src2  = src2_q;

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised successor of the single-cycle decode stage.
- Splits the instruction into opcode, rs1, rs2 and rd, and reads two operands from an internal register file.
- Registers the result into an ID/EX pipeline register with valid/ready handshakes on both sides.
- Adds features the previous generation lacks: a write-back port with its own address, same-cycle write-to-read bypass, flush, optional hardwired-zero R0, and refresh of held operands while stalled.

Parameters:
- DATA_W, 16, width of register data.
- INST_W, 16, instruction width.
- REG_AW, 4, register address width; the register file has 2**REG_AW entries.
- OP_W, INST_W-3*REG_AW (4), opcode field width; derived, not overridable.
- ZERO_REG, 1, when 1, R0 always reads 0 and writes to it are ignored.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_inst  in  INST_W  instruction from fetch. Fields: op=[INST_W-1 -: OP_W], rs1=[3*REG_AW-1 -: REG_AW], rs2=[2*REG_AW-1 -: REG_AW], rd=[REG_AW-1:0].
- i_valid  in  1  i_inst is valid.
- o_ready  out  1  decode can accept i_inst this cycle.
- i_wb_en  in  1  write-back enable.
- i_wb_addr  in  REG_AW  write-back register address.
- i_wb_data  in  DATA_W  write-back data.
- i_flush  in  1  kill the ID/EX contents and the incoming instruction.
- o_valid  out  1  ID/EX register holds a valid decoded instruction.
- i_ready  in  1  execute accepts the ID/EX contents.
- o_op  out  OP_W  registered opcode.
- o_rs1, o_rs2, o_rd  out  REG_AW each  registered register addresses.
- o_src1, o_src2  out  DATA_W each  registered operand data.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - All registers in the register file clear to 0.
  - o_valid=0.
  - o_op, o_rs1, o_rs2, o_rd, o_src1 and o_src2 clear to 0.
  - Reset takes priority over every other input, including during a stall.
- o_ready = !o_valid || i_ready. This is combinational and carries no dependence on i_valid.
- Load condition: ld = i_valid && o_ready && !i_flush. On ld, the ID/EX register captures the fields and operands at the next edge and sets o_valid=1. Latency from i_inst to outputs is 1 cycle.
- Operand read and bypass:
  - src1 = (ZERO_REG && rs1==0) ? 0 : (i_wb_en && i_wb_addr==rs1) ? i_wb_data : rf[rs1].
  - src2 is computed the same way from rs2.
  - This is write-to-read bypass in the same cycle.
- Register-file write: at the edge with i_wb_en=1, rf[i_wb_addr] is written, except address 0 when ZERO_REG=1. Writes are independent of the handshake, stall and flush.
- Drain: if o_valid && i_ready && !ld, then o_valid clears to 0.
- Stall (o_valid && !i_ready && !i_flush):
  - o_op, o_rs1, o_rs2 and o_rd hold.
  - Refresh: if i_wb_en and i_wb_addr==o_rs1 (and not zero-reg R0), o_src1 loads i_wb_data. o_src2 behaves the same against o_rs2. Both may update in the same cycle.
- Flush (i_flush=1, no reset): the next edge sets o_valid=0 and drops the incoming instruction, whatever i_valid and i_ready are. Data outputs may hold stale values. Write-back still occurs.
- Dual source: when rs1==rs2, both operands read the same value, and the bypass applies to both.
- o_* data values are don't-care when o_valid=0. The bench checks them only when o_valid=1.

Decomposition:
- Shared package:
  - Field-slicing constants: OP_W and the field offsets.
  - Opcode enumeration for the later opcode decoder, not used here.
- Sub-module regfile_2r1w, parametrised by DATA_W, REG_AW and ZERO_REG:
  - Synchronous write with synchronous reset.
  - Combinational reads with internal write bypass.
  - It is instantiated once.
- The ID/EX register, handshake and refresh logic sit in the top.

Test Plan:
1. Reset, then write back R3=0x1234 and R5=0x00FF. Then send inst 0x1353 (op=1, rs1=3, rs2=5, rd=3) with i_valid=1 and i_ready=1 -> the next cycle shows o_valid=1, o_op=1, o_src1=0x1234, o_src2=0x00FF, o_rd=3.
2. In the same cycle, i_wb_en=1, i_wb_addr=7, i_wb_data=0xBEEF, and inst rs1=7 -> o_src1=0xBEEF (bypass). A later read of R7 also gives 0xBEEF.
3. Write back R0=0xFFFF with ZERO_REG=1, then read rs1=0 -> o_src1=0. With ZERO_REG=0 -> o_src1=0xFFFF.
4. Hold i_ready=0 with o_valid=1 and o_rs2=5, and write back R5=0xA5A5 -> o_ready=0, o_rd/o_op are unchanged, and o_src2 becomes 0xA5A5 the next cycle. Then raise i_ready -> the next instruction loads.
5. Assert i_flush for one cycle with i_valid=1 and o_valid=1 -> o_valid=0 the next cycle and the instruction is not captured. A wb write that same cycle is still visible on a later read.
6. Assert i_reset for one cycle mid-stall with R3=0x1234 -> o_valid=0 and all outputs are 0. A subsequent read of R3 gives 0x0000.
